// File: rtl/fpga_test_sequencer_if.sv
// Program-under-test handshake bundle between the sequencer and the harness.
// The sequencer (master) selects a program and pulses run. The harness
// (slave) answers with finished/success for the selected program.
interface fpga_test_sequencer_if #(
    parameter int unsigned PW = 3
);
    logic [PW-1:0] progSel;
    logic          progRun;
    logic          progFinished;
    logic          progSuccess;

    modport master (
        output progSel,
        output progRun,
        input  progFinished,
        input  progSuccess
    );

    modport slave (
        input  progSel,
        input  progRun,
        output progFinished,
        output progSuccess
    );
endinterface

// File: rtl/fpga_test_sequencer.sv
// fpga_test_sequencer: launches each program of the bank in turn, waits for
// its finished flag or a step timeout, and tallies pass/fail results into an
// overall verdict.
// Optional feature macro: FPGA_TEST_SEQUENCER_STOP_ON_FAIL_EN. When it is
// defined, the first failing program ends the sequence early.
module fpga_test_sequencer #(
    parameter int unsigned NProgs    = 4,
    parameter int unsigned MaxCycles = 1024,
    parameter int unsigned PW        = $clog2(NProgs + 1),
    parameter int unsigned CW        = $clog2(MaxCycles + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    fpga_test_sequencer_if.master        prog,
    output logic                         busy,
    output logic                         done,
    output logic [PW-1:0]                passCount,
    output logic [PW-1:0]                failCount,
    output logic                         timedOut,
    output logic                         allPassed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RECORD,
        S_DONE
    } state_t;

    localparam logic [PW-1:0] LAST_SEL  = PW'(NProgs - 1);
    localparam logic [PW-1:0] ALL_PROGS = PW'(NProgs);
    localparam logic [CW-1:0] LAST_TICK = CW'(MaxCycles - 1);

    state_t        state;
    logic [CW-1:0] timer;
    logic          result;
    logic [PW-1:0] prog_sel;
    logic          prog_run;

    logic [PW-1:0] pass_nxt_c;
    logic [PW-1:0] fail_nxt_c;
    logic          last_prog_c;
    logic          stop_now_c;

    assign prog.progSel = prog_sel;
    assign prog.progRun = prog_run;

    // Tally values as they will be after the current RECORD cycle.
    assign pass_nxt_c  = passCount + PW'(result);
    assign fail_nxt_c  = failCount + PW'(~result);
    assign last_prog_c = (prog_sel == LAST_SEL);

`ifdef FPGA_TEST_SEQUENCER_STOP_ON_FAIL_EN
    assign stop_now_c = last_prog_c || !result;
`else
    assign stop_now_c = last_prog_c;
`endif

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            result    <= 1'b0;
            prog_sel  <= '0;
            prog_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            passCount <= '0;
            failCount <= '0;
            timedOut  <= 1'b0;
            allPassed <= 1'b0;
        end else begin
            prog_run <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        passCount <= '0;
                        failCount <= '0;
                        timedOut  <= 1'b0;
                        allPassed <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        prog_sel  <= '0;
                        prog_run  <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // A finished flag here is stale from the previous program.
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + CW'(1);
                    if (prog.progFinished) begin
                        result <= prog.progSuccess;
                        state  <= S_RECORD;
                    end else if (timer == LAST_TICK) begin
                        result   <= 1'b0;
                        timedOut <= 1'b1;
                        state    <= S_RECORD;
                    end
                end
                S_RECORD: begin
                    passCount <= pass_nxt_c;
                    failCount <= fail_nxt_c;
                    if (stop_now_c) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        allPassed <= (fail_nxt_c == '0) && (pass_nxt_c == ALL_PROGS);
                        state     <= S_DONE;
                    end else begin
                        prog_sel <= prog_sel + PW'(1);
                        prog_run <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_test_sequencer.sv
// Self-checking bench for fpga_test_sequencer with a behavioural program
// harness and an arithmetic model of launch timing and verdict.
module tb_fpga_test_sequencer;

    localparam int unsigned NP = 4;
    localparam int unsigned MC = 16;
    localparam int unsigned PW = $clog2(NP + 1);

    logic          clock;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [PW-1:0] passCount;
    logic [PW-1:0] failCount;
    logic          timedOut;
    logic          allPassed;

    fpga_test_sequencer_if #(.PW(PW)) bus ();

    fpga_test_sequencer #(
        .NProgs   (NP),
        .MaxCycles(MC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .prog     (bus.master),
        .busy     (busy),
        .done     (done),
        .passCount(passCount),
        .failCount(failCount),
        .timedOut (timedOut),
        .allPassed(allPassed)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Harness behaviour per program: finish in WAIT cycle lat (0-based).
    int lat   [NP];
    bit succ  [NP];
    bit never [NP];
    bit stale = 1'b0;

    int launch_idx[$];
    int launch_cyc[$];
    int busy_err = 0;

    int h_idx = 0;
    int h_cnt = 0;
    bit h_pending = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Program harness: reacts to run pulses, logs launches, drives finished.
    always @(negedge clock) begin
        if (reset) begin
            h_pending = 1'b0;
            bus.progFinished = stale;
            bus.progSuccess  = 1'b0;
        end else if (bus.progRun) begin
            launch_idx.push_back(int'(bus.progSel));
            launch_cyc.push_back(cyc);
            if (busy !== 1'b1) busy_err++;
            h_idx = int'(bus.progSel) % NP;
            h_cnt = 0;
            h_pending = 1'b1;
            bus.progFinished = stale;
            bus.progSuccess  = stale ? !succ[h_idx] : 1'b0;
        end else if (h_pending) begin
            if (!never[h_idx] && h_cnt == lat[h_idx]) begin
                bus.progFinished = 1'b1;
                bus.progSuccess  = succ[h_idx];
                h_pending = 1'b0;
            end else begin
                bus.progFinished = 1'b0;
                bus.progSuccess  = 1'b0;
            end
            h_cnt++;
        end else begin
            bus.progFinished = stale;
            bus.progSuccess  = 1'b0;
        end
    end

    // Pulse start, wait for done, then compare launches and verdict to the model.
    task automatic run_seq(input string tag);
        int exp_pass = 0;
        int exp_fail = 0;
        bit exp_to = 1'b0;
        int exp_n = 0;
        int exp_last = 0;
        int exp_cyc[$];
        int s;
        int t;
        int eff;
        bit failed;
        bit exp_all;
        int waited = 0;

        launch_idx.delete();
        launch_cyc.delete();
        busy_err = 0;

        @(negedge clock);
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;

        t = s + 1;
        for (int i = 0; i < int'(NP); i++) begin
            exp_n++;
            exp_last = i;
            exp_cyc.push_back(t);
            if (never[i] || lat[i] >= int'(MC)) begin
                failed = 1'b1;
                exp_to = 1'b1;
                eff = int'(MC) - 1;
            end else begin
                failed = !succ[i];
                eff = lat[i];
            end
            if (failed) exp_fail++;
            else exp_pass++;
            t = t + eff + 3;
`ifdef FPGA_TEST_SEQUENCER_STOP_ON_FAIL_EN
            if (failed) break;
`endif
        end
        exp_all = (exp_fail == 0) && (exp_pass == int'(NP));

        while (done !== 1'b1 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done-wait: done=%b after %0d cycles, required 1", tag, done, waited);
        end

        n_tests++;
        if (launch_idx.size() != exp_n) begin
            n_fail++;
            $display("FAIL %s launch-count: got %0d required %0d", tag, launch_idx.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < launch_idx.size(); i++) begin
            n_tests++;
            if (launch_idx[i] != i || launch_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL %s launch[%0d]: idx %0d at cycle %0d, required idx %0d at cycle %0d",
                         tag, i, launch_idx[i], launch_cyc[i], i, exp_cyc[i]);
            end
        end
        n_tests++;
        if (busy_err != 0) begin
            n_fail++;
            $display("FAIL %s busy-at-launch: %0d launches with busy low, required 0", tag, busy_err);
        end
        n_tests++;
        if (passCount !== PW'(exp_pass)) begin
            n_fail++;
            $display("FAIL %s passCount: got %0d required %0d", tag, passCount, exp_pass);
        end
        n_tests++;
        if (failCount !== PW'(exp_fail)) begin
            n_fail++;
            $display("FAIL %s failCount: got %0d required %0d", tag, failCount, exp_fail);
        end
        n_tests++;
        if (timedOut !== exp_to) begin
            n_fail++;
            $display("FAIL %s timedOut: got %b required %b", tag, timedOut, exp_to);
        end
        n_tests++;
        if (allPassed !== exp_all) begin
            n_fail++;
            $display("FAIL %s allPassed: got %b required %b", tag, allPassed, exp_all);
        end
        n_tests++;
        if (busy !== 1'b0 || bus.progRun !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle-flags: busy=%b progRun=%b required 0/0", tag, busy, bus.progRun);
        end
        n_tests++;
        if (bus.progSel !== PW'(exp_last)) begin
            n_fail++;
            $display("FAIL %s progSel: got %0d required %0d", tag, bus.progSel, exp_last);
        end
    endtask

    task automatic set_all(input int l, input bit s);
        for (int i = 0; i < int'(NP); i++) begin
            lat[i] = l;
            succ[i] = s;
            never[i] = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (bus.progSel !== '0 || bus.progRun !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ctrl: progSel=%0d progRun=%b busy=%b done=%b required 0/0/0/0",
                     tag, bus.progSel, bus.progRun, busy, done);
        end
        n_tests++;
        if (passCount !== '0 || failCount !== '0) begin
            n_fail++;
            $display("FAIL %s counts: pass=%0d fail=%0d required 0/0", tag, passCount, failCount);
        end
        n_tests++;
        if (timedOut !== 1'b0 || allPassed !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flags: timedOut=%b allPassed=%b required 0/0", tag, timedOut, allPassed);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("reset-idle");
    endtask

    task automatic test_all_pass();
        set_all(9, 1'b1);
        run_seq("all-pass");
    endtask

    task automatic test_one_fail();
        set_all(9, 1'b1);
        succ[2] = 1'b0;
        run_seq("one-fail");
    endtask

    task automatic test_timeout();
        set_all(4, 1'b1);
        never[1] = 1'b1;
        run_seq("timeout");
    endtask

    task automatic test_finish_at_timeout();
        set_all(2, 1'b1);
        lat[0] = int'(MC) - 1;
        lat[3] = int'(MC) - 1;
        succ[3] = 1'b0;
        run_seq("finish-at-timeout");
    endtask

    task automatic test_stale();
        for (int i = 0; i < int'(NP); i++) begin
            lat[i] = $urandom_range(1, 6);
            succ[i] = 1'($urandom_range(0, 1));
            never[i] = 1'b0;
        end
        stale = 1'b1;
        run_seq("stale");
        stale = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'(NP); i++) begin
                lat[i] = $urandom_range(0, 20);
                succ[i] = ($urandom_range(0, 3) != 0);
                never[i] = (lat[i] >= int'(MC));
            end
            run_seq($sformatf("random%0d", r));
        end
    endtask

    task automatic test_reset_mid_run();
        int waited = 0;
        set_all(8, 1'b1);
        launch_idx.delete();
        launch_cyc.delete();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (launch_idx.size() < 3 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        n_tests++;
        if (launch_idx.size() < 3) begin
            n_fail++;
            $display("FAIL reset-mid launch-wait: %0d launches seen, required 3", launch_idx.size());
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("reset-mid");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        set_all(3, 1'b1);
        succ[0] = 1'b0;
        run_seq("after-reset");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_all(1, 1'b1);
        test_reset();
        test_all_pass();
        test_one_fail();
        test_timeout();
        test_finish_at_timeout();
        test_stale();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
